// File: rtl/mem_access_pkg.sv
// Shared constants, bus command record and store-lane helpers for the mem_access load/store unit.
package mem_access_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_REQ  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } bus_cmd_t;

  // Undefined width codes and misaligned halves/words never reach the bus.
  function automatic logic access_fault(input logic [2:0] f3, input logic [1:0] off);
    logic fault;
    case (f3)
      F3_B, F3_BU: fault = 1'b0;
      F3_H, F3_HU: fault = off[0];
      F3_W:        fault = (off != 2'b00);
      default:     fault = 1'b1;
    endcase
    return fault;
  endfunction

  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] strb;
    case (f3[1:0])
      2'b00:   strb = 4'b0001 << off;
      2'b01:   strb = off[1] ? 4'b1100 : 4'b0011;
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] data;
    case (f3[1:0])
      2'b00:   data = {4{wd[7:0]}};
      2'b01:   data = {2{wd[15:0]}};
      default: data = wd;
    endcase
    return data;
  endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// Load lane select and sign/zero extension of the bus read word.
module mem_load_align
  import mem_access_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (off_i)
      2'b00:   byte_sel = word_i[7:0];
      2'b01:   byte_sel = word_i[15:8];
      2'b10:   byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase
    half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];

    case (funct3_i)
      F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data_o = {24'h000000, byte_sel};
      F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data_o = {16'h0000, half_sel};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Load/store unit: runs one req/ack data-bus transaction per accepted start and returns extended load data.
// Optional REQ timeout is compiled in with `define MEM_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | waiting for start; start is only sampled here
// REQ     | bus_req high, command registers held until bus_ack (or timeout)
// DONE    | done pulse for one cycle, err/rdata valid
module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("mem_access: TIMEOUT_CYCLES must be at least 1");
  end

  logic [1:0]  state_q, state_d;
  bus_cmd_t    cmd_q, cmd_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  f3_q, f3_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] load_val;
  logic        tmo_expired;

  mem_load_align u_load_align (
    .word_i   (bus_rdata),
    .off_i    (off_q),
    .funct3_i (f3_q),
    .data_o   (load_val)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] tmo_q, tmo_d;

  // Reloaded every IDLE cycle so each REQ phase starts with a full budget.
  always_comb begin
    tmo_d = tmo_q;
    if (state_q == ST_IDLE) begin
      tmo_d = TW'(TIMEOUT_CYCLES - 1);
    end else if ((state_q == ST_REQ) && (tmo_q != '0)) begin
      tmo_d = tmo_q - TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end

  assign tmo_expired = (tmo_q == '0);
`else
  assign tmo_expired = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    off_d   = off_q;
    f3_d    = f3_q;
    err_d   = err_q;
    rdata_d = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          err_d = 1'b0;
          if (!mem_read && !mem_write) begin
            rdata_d = '0;
            state_d = ST_DONE;
          end else if (access_fault(funct3, addr[1:0])) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            cmd_d.we    = mem_write;
            cmd_d.addr  = {addr[31:2], 2'b00};
            cmd_d.wstrb = mem_write ? store_strb(funct3, addr[1:0]) : 4'b0000;
            cmd_d.wdata = mem_write ? store_data(funct3, wdata) : 32'h0;
            off_d       = addr[1:0];
            f3_d        = funct3;
            state_d     = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        // An ack on the terminal timeout cycle still completes normally.
        if (bus_ack) begin
          if (!cmd_q.we) begin
            rdata_d = load_val;
          end
          state_d = ST_DONE;
        end else if (tmo_expired) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
      off_q   <= 2'b00;
      f3_q    <= 3'b000;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign bus_req   = (state_q == ST_REQ);
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign bus_we    = cmd_q.we;
  assign bus_addr  = cmd_q.addr;
  assign bus_wstrb = cmd_q.wstrb;
  assign bus_wdata = cmd_q.wdata;

endmodule
